// File: rtl/cpu_pkg.sv
// Shared front-end types: fetch FSM state encoding, instruction size and default vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage : cpu_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC selection: trap > redirect > sequential > hold, plus misaligned-redirect detection.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int unsigned                    INSTRUCTION_BITSIZE = 32,
  parameter logic [INSTRUCTION_BITSIZE-1:0] TRAP_VECTOR         = INSTRUCTION_BITSIZE'(DEFAULT_TRAP_VECTOR)
) (
  input  logic [INSTRUCTION_BITSIZE-1:0] pc_i,
  input  logic                           advance_i,
  input  logic                           trap_i,
  input  logic                           redirect_valid_i,
  input  logic [INSTRUCTION_BITSIZE-1:0] redirect_target_i,
  output logic [INSTRUCTION_BITSIZE-1:0] pc_next_o,
  output logic                           flow_change_o,
  output logic                           misalign_o
);

  assign flow_change_o = trap_i | redirect_valid_i;
  assign misalign_o    = redirect_valid_i & ~trap_i & (redirect_target_i[1:0] != 2'b00);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves pc_next_o unassigned (no latch).
    pc_next_o = pc_i;
    if (trap_i) begin
      pc_next_o = TRAP_VECTOR;
    end else if (redirect_valid_i) begin
      pc_next_o = misalign_o ? TRAP_VECTOR : redirect_target_i;
    end else if (advance_i) begin
      pc_next_o = pc_i + INSTRUCTION_BITSIZE'(INSTR_BYTES);
    end
  end

endmodule : fetch_next_pc

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one-outstanding imem fetches and
// presents {pc, instr} to decode; redirects/traps squash in-flight work.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned                    INSTRUCTION_BITSIZE = 32,
  parameter logic [INSTRUCTION_BITSIZE-1:0] RESET_VECTOR        = INSTRUCTION_BITSIZE'(DEFAULT_RESET_VECTOR),
  parameter logic [INSTRUCTION_BITSIZE-1:0] TRAP_VECTOR         = INSTRUCTION_BITSIZE'(DEFAULT_TRAP_VECTOR)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [INSTRUCTION_BITSIZE-1:0] imem_req_addr,
  input  logic                           imem_rsp_valid,
  input  logic [INSTRUCTION_BITSIZE-1:0] imem_rsp_data,
  input  logic                           redirect_valid,
  input  logic [INSTRUCTION_BITSIZE-1:0] redirect_target,
  input  logic                           trap,
  output logic                           if_valid,
  input  logic                           if_ready,
  output logic [INSTRUCTION_BITSIZE-1:0] if_pc,
  output logic [INSTRUCTION_BITSIZE-1:0] if_instr,
  output logic                           misalign_fault
);

  fetch_state_e                   state_q;
  logic [INSTRUCTION_BITSIZE-1:0] pc_q;
  logic [INSTRUCTION_BITSIZE-1:0] if_pc_q;
  logic [INSTRUCTION_BITSIZE-1:0] if_instr_q;
  logic                           kill_q;
  logic                           req_valid_q;
  logic                           if_valid_q;
  logic                           fault_q;

  logic                           active;
  logic                           handshake;
  logic                           consume;
  logic                           flow_change;
  logic                           misalign;
  logic [INSTRUCTION_BITSIZE-1:0] pc_next;

  assign active    = (state_q != ST_BOOT);
  assign handshake = req_valid_q & imem_req_ready;
  assign consume   = (state_q == ST_HOLD) & if_valid_q & if_ready;

  fetch_next_pc #(
    .INSTRUCTION_BITSIZE(INSTRUCTION_BITSIZE),
    .TRAP_VECTOR        (TRAP_VECTOR)
  ) u_next_pc (
    .pc_i             (pc_q),
    .advance_i        (consume),
    .trap_i           (trap),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .pc_next_o        (pc_next),
    .flow_change_o    (flow_change),
    .misalign_o       (misalign)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (active) begin
        pc_q <= pc_next;
      end

      if (active && flow_change) begin
        fault_q    <= misalign;
        if_valid_q <= 1'b0;
        // A request already in memory must have its response swallowed before refetching.
        if (handshake || (state_q == ST_WAIT && !imem_rsp_valid)) begin
          kill_q      <= 1'b1;
          req_valid_q <= 1'b0;
          state_q     <= ST_WAIT;
        end else begin
          kill_q      <= 1'b0;
          req_valid_q <= 1'b1;
          state_q     <= ST_REQ;
        end
      end else begin
        case (state_q)
          ST_BOOT: begin
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
          ST_REQ: begin
            if (imem_req_ready) begin
              req_valid_q <= 1'b0;
              state_q     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              if (kill_q) begin
                kill_q      <= 1'b0;
                req_valid_q <= 1'b1;
                state_q     <= ST_REQ;
              end else begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= imem_rsp_data;
                state_q    <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (if_ready) begin
              if_valid_q  <= 1'b0;
              req_valid_q <= 1'b1;
              state_q     <= ST_REQ;
            end
          end
          default: begin
            req_valid_q <= 1'b0;
            state_q     <= ST_BOOT;
          end
        endcase
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign misalign_fault = fault_q;

endmodule : fetch_sequencer
